// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine
//
// Time-multiplexed AES SubBytes / SubWord engine. A NUM_BYTES-wide word is
// latched on an input handshake, then substituted in place LANES bytes per
// cycle through LANES shared S-box lookups. The finished word is presented
// on the output handshake and held until the consumer takes it. The same
// block serves the key schedule (NUM_BYTES=4) and the round state
// (NUM_BYTES=16).
//
// Parameters:
//   NUM_BYTES  bytes per word
//   LANES      S-box lookups per cycle; must divide NUM_BYTES
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   inv        (only with INV_SBOX_EN) 1 = inverse S-box for this word
//   in_data    word to substitute, byte 0 in the most significant byte
//   in_valid   in_data is valid
//   in_ready   engine can accept a word this cycle
//   out_data   substituted word, same byte order
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//
// Build option:
//   INV_SBOX_EN  when defined, adds the inv port and per-lane inverse tables.
//                When undefined, only the forward S-box is built.

module sub_bytes_engine #(
  parameter int NUM_BYTES = 4,
  parameter int LANES     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef INV_SBOX_EN
  input  logic                   inv,
`endif
  input  logic [NUM_BYTES*8-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_BYTES*8-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int BEATS   = NUM_BYTES / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CHUNK_W = LANES * 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  generate
    if (LANES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_cfg
      $error("sub_bytes_engine: LANES (%0d) must divide NUM_BYTES (%0d)", LANES, NUM_BYTES);
    end
  endgenerate

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255-x)*8, and 255-x is simply ~x for a byte.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_FWD[idx +: 8];
  endfunction

`ifdef INV_SBOX_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_INV[idx +: 8];
  endfunction
`endif

  logic [1:0]             state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [NUM_BYTES*8-1:0] work_q, work_d;
`ifdef INV_SBOX_EN
  logic                   inv_q, inv_d;
`endif

  logic [CHUNK_W-1:0] chunk_in;
  logic [CHUNK_W-1:0] chunk_out;

  // in_ready depends only on state, out_ready and reset, never on in_valid.
  assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = work_q;

  // Beat b covers bytes b*LANES.., which are the b-th chunk from the top
  // of the big-endian work register. A mux over beats avoids a variable
  // part-select on the wide register.
  always_comb begin
    chunk_in = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        chunk_in = work_q[(BEATS-1-b)*CHUNK_W +: CHUNK_W];
      end
    end
  end

  // One S-box lookup (forward, plus inverse when enabled) per lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] lane_in;
    logic [7:0] fwd_out;
    assign lane_in = chunk_in[(LANES-1-l)*8 +: 8];
    assign fwd_out = sbox_fwd(lane_in);
`ifdef INV_SBOX_EN
    logic [7:0] inv_out;
    assign inv_out = sbox_inv(lane_in);
    assign chunk_out[(LANES-1-l)*8 +: 8] = inv_q ? inv_out : fwd_out;
`else
    assign chunk_out[(LANES-1-l)*8 +: 8] = fwd_out;
`endif
  end

  // Sequencing: accept a word, substitute one chunk per cycle, then hold
  // the result until taken. A new word may be accepted in the same cycle
  // the old one leaves, so back-to-back words cost no idle cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    work_d  = work_q;
`ifdef INV_SBOX_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_data;
          beat_d  = '0;
          state_d = ST_BUSY;
`ifdef INV_SBOX_EN
          inv_d   = inv;
`endif
        end
      end
      ST_BUSY: begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_q == BEAT_W'(b)) begin
            work_d[(BEATS-1-b)*CHUNK_W +: CHUNK_W] = chunk_out;
          end
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid && in_ready) begin
            work_d  = in_data;
            beat_d  = '0;
            state_d = ST_BUSY;
`ifdef INV_SBOX_EN
            inv_d   = inv;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      work_q  <= '0;
`ifdef INV_SBOX_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      work_q  <= work_d;
`ifdef INV_SBOX_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule
